// File: rtl/booth_seq_mul.sv
// -----------------------------------------------------------------------------
// booth_seq_mul
//
// Iterative 8x8 signed radix-4 Booth multiplier. One 9-bit partial-product
// decoder row (decoder_9) is reused over four cycles. Each cycle encodes the
// next multiplier triplet into neg/one/two, sign-extends and aligns the
// decoded row, and accumulates it into a 16-bit product.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair offered
//   in_ready   block can accept operands (IDLE only)
//   mc, mp     multiplicand / multiplier, two's complement, 8 bits
//   out_valid  product valid (DONE only)
//   out_ready  sink accepts product
//   product    signed 16-bit result mc*mp
//   busy       high in RUN or DONE
//   row        current Booth row index (debug)
// -----------------------------------------------------------------------------

// One Booth partial-product row: selects 0, +mc or +2mc and inverts for
// negative digits. The +1 completing the two's complement is added by the
// caller, so the output is a ones'-complement row.
module decoder_9 (
  input  logic [7:0] i_mc,
  input  logic       i_neg,
  input  logic       i_one,
  input  logic       i_two,
  output logic [8:0] o_dec
);

  logic [8:0] w_mag;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_mag = 9'd0;
    if (i_one)      w_mag = {i_mc[7], i_mc};
    else if (i_two) w_mag = {i_mc, 1'b0};
    o_dec = w_mag ^ {9{i_neg}};
  end

endmodule

module booth_seq_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  mc,
  input  logic [7:0]  mp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy,
  output logic [1:0]  row
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mc;
  logic [7:0]  r_mp;
  logic [15:0] r_acc;
  logic [1:0]  r_row;

  logic [8:0]  w_mp_ext;
  logic [3:0]  w_idx;
  logic [2:0]  w_trip;
  logic        w_neg;
  logic        w_one;
  logic        w_two;
  logic [8:0]  w_dec;
  logic [15:0] w_row_val;
  logic [15:0] w_contrib;

  // Multiplier with the implicit mp[-1]=0 appended, so row i reads bits
  // [2i+2:2i] of this vector as its triplet.
  assign w_mp_ext = {r_mp, 1'b0};
  assign w_idx    = {1'b0, r_row, 1'b0};
  assign w_trip   = w_mp_ext[w_idx +: 3];

  // Radix-4 Booth encoder. 111 maps to a plain zero (neg=0) so that an
  // all-ones run does not add a stray +1.
  always_comb begin
    w_neg = 1'b0;
    w_one = 1'b0;
    w_two = 1'b0;
    case (w_trip)
      3'b001, 3'b010: w_one = 1'b1;
      3'b011:         w_two = 1'b1;
      3'b100: begin
        w_neg = 1'b1;
        w_two = 1'b1;
      end
      3'b101, 3'b110: begin
        w_neg = 1'b1;
        w_one = 1'b1;
      end
      default: ;
    endcase
  end

  decoder_9 u_dec (
    .i_mc  (r_mc),
    .i_neg (w_neg),
    .i_one (w_one),
    .i_two (w_two),
    .o_dec (w_dec)
  );

  // Sign-extend the ones'-complement row, add neg to finish the negation,
  // then align to weight 4^i.
  assign w_row_val = {{7{w_dec[8]}}, w_dec} + {15'd0, w_neg};
  assign w_contrib = w_row_val << {r_row, 1'b0};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_row == 2'd3) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  // Datapath. Operands are captured only on accept, so input changes while
  // busy cannot disturb the running multiply. The row counter wraps 3->0 as
  // the block enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc  <= 8'd0;
      r_mp  <= 8'd0;
      r_acc <= 16'd0;
      r_row <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mc  <= mc;
            r_mp  <= mp;
            r_acc <= 16'd0;
            r_row <= 2'd0;
          end
        end
        ST_RUN: begin
          r_acc <= r_acc + w_contrib;
          r_row <= r_row + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = r_acc;
  assign row     = r_row;

endmodule

// File: tb/tb_booth_seq_mul.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mul
//
// Self-checking bench for booth_seq_mul. Expected products come from plain
// signed integer multiplication. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_booth_seq_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mc;
  logic [7:0]  mp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [1:0]  row;

  int n_cmp;
  int n_err;
  int n_acc;
  int n_res;

  booth_seq_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mc        (mc),
    .mp        (mp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .row       (row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int pa;
    int pb;
    int p;
    pa = int'($signed(a));
    pb = int'($signed(b));
    p  = pa * pb;
    return p[15:0];
  endfunction

  // Must be called at a falling edge with the DUT idle. Offers one operand
  // pair, checks latency and result, applies 'stall' cycles of backpressure,
  // completes the handshake and returns at the falling edge after it.
  // With 'noise' set, junk in_valid/mc/mp are driven while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int stall, input bit noise, input string tag);
    logic [15:0] exp;
    int          k;
    exp = ref_mul(a, b);
    in_valid  = 1'b1;
    mc        = a;
    mp        = b;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", tag, in_ready);
    end
    @(posedge clk);
    n_acc++;
    @(negedge clk);
    in_valid = noise ? 1'($urandom) : 1'b0;
    mc       = noise ? 8'($urandom) : mc;
    mp       = noise ? 8'($urandom) : mp;
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s run_flags: got in_ready=%b busy=%b want 0/1", tag, in_ready, busy);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      if (noise) begin
        in_valid = 1'($urandom);
        mc       = 8'($urandom);
        mp       = 8'($urandom);
      end
    end
    n_cmp++;
    if (k != 4) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles want 4", tag, k);
    end
    n_cmp++;
    if (product !== exp) begin
      n_err++;
      $display("FAIL %s product: mc=%0d mp=%0d got 0x%04h want 0x%04h",
               tag, $signed(a), $signed(b), product, exp);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (noise) begin
        in_valid = 1'($urandom);
        mc       = 8'($urandom);
        mp       = 8'($urandom);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp) begin
        n_err++;
        $display("FAIL %s stall%0d: got out_valid=%b in_ready=%b product=0x%04h want 1/0/0x%04h",
                 tag, s, out_valid, in_ready, product, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (out_valid === 1'b1) n_res++;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s post_handshake: got out_valid=%b in_ready=%b busy=%b want 0/1/0",
               tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mc        = 8'd0;
    mp        = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        product !== 16'h0000 || row !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b product=0x%04h row=%0d want 1/0/0/0x0000/0",
               in_ready, out_valid, busy, product, row);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(8'd3, 8'd5, 0, 1'b0, "basic_3x5");
  endtask

  task automatic test_corners();
    run_op(8'h80, 8'h80, 0, 1'b0, "m128xm128");
    run_op(8'h7F, 8'h80, 0, 1'b0, "127xm128");
    run_op(8'hFF, 8'h7F, 0, 1'b0, "m1x127");
    run_op(8'h55, 8'hFF, 0, 1'b0, "mp_all_ones");
    run_op(8'h00, 8'hA7, 0, 1'b0, "mc_zero");
    run_op(8'h00, 8'h80, 0, 1'b0, "mc_zero_b");
  endtask

  task automatic test_backpressure();
    run_op(8'd7, 8'hF7, 3, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid_run();
    in_valid = 1'b1;
    mc       = 8'd93;
    mp       = 8'hB5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (row !== 2'd2 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_run_row: got row=%0d busy=%b want 2/1", row, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        row !== 2'd0 || product !== 16'h0000) begin
      n_err++;
      $display("FAIL mid_run_reset: got in_ready=%b out_valid=%b busy=%b row=%0d product=0x%04h want 1/0/0/0/0x0000",
               in_ready, out_valid, busy, row, product);
    end
    run_op(8'd2, 8'd3, 0, 1'b0, "after_reset_2x3");
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    int         st;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      run_op(a, b, st, 1'b1, "random");
    end
    n_cmp++;
    if (n_res != n_acc) begin
      n_err++;
      $display("FAIL result_count: got %0d results want %0d", n_res, n_acc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_acc = 0;
    n_res = 0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
